// File: rtl/if_id_queue_pkg.sv
// Shared defines for the IF/ID instruction queue: bus widths, zero word,
// reset polarity and the default queue depth.
package if_id_queue_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam int   InstAddrBus = 32;
  localparam int   InstBus     = 32;
  localparam int   ExceptBus   = 32;
  localparam int   IfqDepth    = 4;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/ifq_ptr.sv
// Wrapping queue pointer. Reset and clear take it to zero, and inc advances it
// by one. It wraps naturally at 2**W.
module ifq_ptr
  import if_id_queue_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst == RstEnable || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry circular FIFO with first-word
// fall-through and an all-zero bubble when empty. Define IFQ_EXC_FENCE_EN to
// stop accepting entries after a faulting fetch until that entry is consumed.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH  = IfqDepth,
  parameter int ADDR_W = InstAddrBus,
  parameter int INST_W = InstBus,
  parameter int EXC_W  = ExceptBus
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic [INST_W-1:0]          if_inst,
  input  logic [EXC_W-1:0]           if_excepttype,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic [EXC_W-1:0]           id_excepttype,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [EXC_W-1:0]  exc_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_reg;
  logic             push;
  logic             pop;
  logic             fence;

  assign id_valid = (count_reg != '0);
  assign if_ready = (rst != RstEnable) && (count_reg != CNT_W'(DEPTH)) && !fence;
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & id_ready;
  assign count    = count_reg;

  ifq_ptr #(.W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (wr_ptr)
  );

  ifq_ptr #(.W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush) begin
      count_reg <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is never reset; it is only observable through a non-empty head.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]   <= if_pc;
      inst_mem[wr_ptr] <= if_inst;
      exc_mem[wr_ptr]  <= if_excepttype;
    end
  end

  assign id_pc         = id_valid ? pc_mem[rd_ptr]   : '0;
  assign id_inst       = id_valid ? inst_mem[rd_ptr] : '0;
  assign id_excepttype = id_valid ? exc_mem[rd_ptr]  : '0;

`ifdef IFQ_EXC_FENCE_EN
  logic             fence_reg;
  logic [PTR_W-1:0] fence_idx_reg;

  // While fenced no push can occur, so arming and releasing never collide.
  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush) begin
      fence_reg <= 1'b0;
    end else if (push && (if_excepttype != '0)) begin
      fence_reg     <= 1'b1;
      fence_idx_reg <= wr_ptr;
    end else if (pop && fence_reg && (rd_ptr == fence_idx_reg)) begin
      fence_reg <= 1'b0;
    end
  end

  assign fence = fence_reg;
`else
  assign fence = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Randomised and directed bench for if_id_queue, checked against a queue-based
// reference model. It adapts to IFQ_EXC_FENCE_EN when that macro is defined.
module tb_if_id_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic [31:0] if_excepttype = '0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] id_excepttype;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  bit model_on = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exc;
  } entry_t;

  entry_t model_q[$];

  if_id_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32), .EXC_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_excepttype (if_excepttype),
    .id_ready      (id_ready),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_excepttype (id_excepttype),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_fenced();
`ifdef IFQ_EXC_FENCE_EN
    foreach (model_q[i]) if (model_q[i].exc != 0) return 1;
`endif
    return 0;
  endfunction

  // Compare on the falling edge, then advance the model to the state after the coming rising edge.
  always @(negedge clk) begin
    if (model_on) begin
      logic        exp_ready, exp_valid, push, pop;
      logic [31:0] exp_pc, exp_inst, exp_exc;
      exp_valid = (model_q.size() != 0);
      exp_ready = !rst && (model_q.size() < DEPTH) && !model_fenced();
      exp_pc    = exp_valid ? model_q[0].pc   : 32'h0;
      exp_inst  = exp_valid ? model_q[0].inst : 32'h0;
      exp_exc   = exp_valid ? model_q[0].exc  : 32'h0;
      check("m_id_valid", 64'(id_valid), 64'(exp_valid));
      check("m_if_ready", 64'(if_ready), 64'(exp_ready));
      check("m_id_pc", 64'(id_pc), 64'(exp_pc));
      check("m_id_inst", 64'(id_inst), 64'(exp_inst));
      check("m_id_exc", 64'(id_excepttype), 64'(exp_exc));
      check("m_count", 64'(count), 64'(model_q.size()));
      push = if_valid && exp_ready;
      pop  = exp_valid && id_ready;
      if (rst || flush) begin
        model_q.delete();
      end else begin
        if (pop) void'(model_q.pop_front());
        if (push) model_q.push_back('{pc: if_pc, inst: if_inst, exc: if_excepttype});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] exc);
    if_valid = v;
    if_pc = pc;
    if_inst = inst;
    if_excepttype = exc;
  endtask

  initial begin
    // Reset, then idle
    rst = 1'b1;
    tick();
    model_on = 1;
    tick();
    rst = 1'b0;
    tick();
    check("idle_valid", 64'(id_valid), 64'd0);
    check("idle_inst", 64'(id_inst), 64'd0);
    check("idle_count", 64'(count), 64'd0);
    check("idle_ready", 64'(if_ready), 64'd1);

    // Single pass-through entry
    id_ready = 1'b1;
    set_push(1'b1, 32'h0040_0000, 32'h2401_0001, 32'h0);
    tick();
    set_push(1'b0, 32'h0, 32'h0, 32'h0);
    check("one_valid", 64'(id_valid), 64'd1);
    check("one_pc", 64'(id_pc), 64'h0040_0000);
    check("one_inst", 64'(id_inst), 64'h2401_0001);
    tick();
    check("one_count", 64'(count), 64'd0);

    // Fill to capacity while ID is stalled, then drain
    id_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_push(1'b1, 32'h0000_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 32'h0);
      tick();
    end
    set_push(1'b1, 32'h0000_BEEF, 32'h0, 32'h0);
    check("full_count", 64'(count), 64'd4);
    check("full_ready", 64'(if_ready), 64'd0);
    tick();
    check("full_hold_pc", 64'(id_pc), 64'h0000_1000);
    set_push(1'b0, 32'h0, 32'h0, 32'h0);
    id_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_pc", 64'(id_pc), 64'h0000_1000 + 64'(4 * i));
      tick();
    end
    check("drain_count", 64'(count), 64'd0);

    // Steady push+pop at count=2 across pointer wrap
    id_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_push(1'b1, 32'h0000_2000 + 32'(4 * i), 32'hB000_0000 + 32'(i), 32'h0);
      tick();
    end
    id_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_push(1'b1, 32'h0000_2008 + 32'(4 * k), 32'hB000_0002 + 32'(k), 32'h0);
      check("steady_pc", 64'(id_pc), 64'h0000_2000 + 64'(4 * k));
      tick();
      check("steady_count", 64'(count), 64'd2);
    end

    // Flush with a simultaneous push at count=3
    id_ready = 1'b0;
    set_push(1'b1, 32'h0000_3000, 32'h1, 32'h0);
    tick();
    check("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1;
    set_push(1'b1, 32'h0000_DEAD, 32'h2, 32'h0);
    tick();
    flush = 1'b0;
    set_push(1'b0, 32'h0, 32'h0, 32'h0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(id_valid), 64'd0);
    check("flush_pc", 64'(id_pc), 64'd0);
    check("flush_ready", 64'(if_ready), 64'd1);
    tick();
    check("flush_dropped", 64'(count), 64'd0);

    // Faulting entry
    set_push(1'b1, 32'h0000_4000, 32'h3, 32'h0000_0008);
    tick();
    set_push(1'b1, 32'h0000_4004, 32'h4, 32'h0);
`ifdef IFQ_EXC_FENCE_EN
    check("fence_ready", 64'(if_ready), 64'd0);
    tick();
    check("fence_hold", 64'(if_ready), 64'd0);
    check("fence_count", 64'(count), 64'd1);
    set_push(1'b0, 32'h0, 32'h0, 32'h0);
    id_ready = 1'b1;
    check("fence_exc", 64'(id_excepttype), 64'h8);
    tick();
    check("fence_release", 64'(if_ready), 64'd1);
`else
    check("nofence_ready", 64'(if_ready), 64'd1);
    check("nofence_exc", 64'(id_excepttype), 64'h8);
    tick();
    check("nofence_count", 64'(count), 64'd2);
    set_push(1'b0, 32'h0, 32'h0, 32'h0);
    id_ready = 1'b1;
    tick();
    tick();
`endif
    id_ready = 1'b0;
    tick();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      flush    = ($urandom_range(0, 24) == 0);
      id_ready = ($urandom_range(0, 1) == 1);
      set_push($urandom_range(0, 9) < 6, $urandom(), $urandom(),
               ($urandom_range(0, 9) == 0) ? $urandom() : 32'h0);
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    set_push(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
